// File: rtl/duty_meas_ctrl.sv
// duty_meas_ctrl
//   Controls a duty-cycle meter. A burst starts from a one-cycle start
//   request: the meter is reset for two cycles, then AVG_N = 2**AVG_LOG2
//   in-range samples are collected. A sample is the rising edge of the
//   stretched meter_valid. The accumulated sum is divided by AVG_N by
//   shifting, and the result is offered on a valid/ready output. Samples
//   outside [DUTY_MIN, DUTY_MAX] are dropped with an err_range pulse. If
//   TIMEOUT_CYC cycles pass without progress, the burst is aborted with an
//   err_timeout pulse.
//
//   Optional build macro DUTY_CTRL_AUTO_EN: adds a free-running period
//   counter. Every PERIOD_CYC cycles it raises an internal trigger, which is
//   OR'd with start and accepted only in IDLE.
//
// Ports
//   clk_10m      in   10 MHz clock, rising edge
//   rst          in   asynchronous reset, active-high
//   start        in   one-cycle burst request (honoured only in IDLE)
//   meter_valid  in   stretched result-valid from the meter
//   meter_duty   in   meter result, 0.01 % units
//   meter_rst    out  registered reset to the meter, active-high
//   out_ready    in   consumer accepts out_duty
//   out_valid    out  averaged result available
//   out_duty     out  averaged duty, 0.01 % units (held after delivery)
//   busy         out  high whenever the controller is not in IDLE
//   err_timeout  out  one-cycle pulse on burst abort by timeout
//   err_range    out  one-cycle pulse per discarded out-of-range sample
module duty_meas_ctrl #(
   parameter int AVG_LOG2    = 2,
   parameter int TIMEOUT_CYC = 20_000_000,
   parameter int PERIOD_CYC  = 5_000_000,
   parameter int DUTY_MIN    = 2000,
   parameter int DUTY_MAX    = 8000
) (
   input  logic        clk_10m,
   input  logic        rst,
   input  logic        start,
   input  logic        meter_valid,
   input  logic [15:0] meter_duty,
   output logic        meter_rst,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_duty,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_range
);

   localparam int              AVG_N    = 1 << AVG_LOG2;
   localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [4:0]      CNT_FULL = 5'(AVG_N);
   localparam logic [15:0]     D_MIN    = 16'(DUTY_MIN);
   localparam logic [15:0]     D_MAX    = 16'(DUTY_MAX);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARM      = 3'd1,
      WAIT_RES = 3'd2,
      WAIT_LOW = 3'd3,
      DONE     = 3'd4,
      ERR      = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [19:0]      acc_q, acc_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             arm_q, arm_d;
   logic             prev_q, prev_d;
   logic [15:0]      out_duty_q, out_duty_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             meter_rst_q, meter_rst_d;
   logic             err_timeout_q, err_timeout_d;
   logic             err_range_q, err_range_d;
   logic             auto_trig_s;
   logic             trig_s;
   logic             sample_ev_s;
   logic             in_range_s;

`ifdef DUTY_CTRL_AUTO_EN
   localparam int              PER_W    = $clog2(PERIOD_CYC + 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);

   logic [PER_W-1:0] per_q, per_d;

   // Free-running period counter; wraps and fires the trigger every PERIOD_CYC cycles
   always_comb begin
      per_d       = per_q + PER_W'(1);
      auto_trig_s = 1'b0;
      if (per_q == PER_LAST) begin
         per_d       = {PER_W{1'b0}};
         auto_trig_s = 1'b1;
      end else begin
         auto_trig_s = 1'b0;
      end
   end

   // Period counter register
   always_ff @(posedge clk_10m or posedge rst) begin
      if (rst) begin
         per_q <= {PER_W{1'b0}};
      end else begin
         per_q <= per_d;
      end
   end
`else
   assign auto_trig_s = 1'b0;
`endif

   assign trig_s      = start | auto_trig_s;
   // Only the rising edge of the stretched valid counts as a sample
   assign sample_ev_s = meter_valid & ~prev_q;
   assign in_range_s  = (meter_duty >= D_MIN) && (meter_duty <= D_MAX);

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      arm_d       = arm_q;
      out_duty_d  = out_duty_q;
      err_range_d = 1'b0;
      prev_d      = meter_valid;

      case (state_q)
         IDLE: begin
            if (trig_s) begin
               acc_d   = 20'd0;
               cnt_d   = 5'd0;
               arm_d   = 1'b0;
               state_d = ARM;
            end else begin
               state_d = IDLE;
            end
         end
         ARM: begin
            // arm_q marks the second meter-reset cycle
            if (arm_q) begin
               tmo_d   = {TMO_W{1'b0}};
               state_d = WAIT_RES;
            end else begin
               arm_d = 1'b1;
            end
         end
         WAIT_RES: begin
            tmo_d = tmo_q + TMO_W'(1);
            // An accepted sample is progress, so it wins over a coincident timeout
            if (sample_ev_s && in_range_s) begin
               acc_d   = acc_q + {4'b0000, meter_duty};
               cnt_d   = cnt_q + 5'd1;
               tmo_d   = {TMO_W{1'b0}};
               state_d = WAIT_LOW;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ERR;
            end else if (sample_ev_s) begin
               err_range_d = 1'b1;
               state_d     = WAIT_LOW;
            end else begin
               state_d = WAIT_RES;
            end
         end
         WAIT_LOW: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_q == TMO_LAST) begin
               state_d = ERR;
            end else if (!meter_valid) begin
               if (cnt_q == CNT_FULL) begin
                  out_duty_d = 16'(acc_q >> AVG_LOG2);
                  state_d    = DONE;
               end else begin
                  state_d = WAIT_RES;
               end
            end else begin
               state_d = WAIT_LOW;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it
      out_valid_d   = (state_d == DONE);
      busy_d        = (state_d != IDLE);
      err_timeout_d = (state_d == ERR);
      meter_rst_d   = (state_d == ARM) || (state_d == ERR);
   end

   // State, datapath and output registers
   always_ff @(posedge clk_10m or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         acc_q         <= 20'd0;
         cnt_q         <= 5'd0;
         tmo_q         <= {TMO_W{1'b0}};
         arm_q         <= 1'b0;
         prev_q        <= 1'b0;
         out_duty_q    <= 16'd0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         meter_rst_q   <= 1'b1;
         err_timeout_q <= 1'b0;
         err_range_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         tmo_q         <= tmo_d;
         arm_q         <= arm_d;
         prev_q        <= prev_d;
         out_duty_q    <= out_duty_d;
         out_valid_q   <= out_valid_d;
         busy_q        <= busy_d;
         meter_rst_q   <= meter_rst_d;
         err_timeout_q <= err_timeout_d;
         err_range_q   <= err_range_d;
      end
   end

   assign meter_rst   = meter_rst_q;
   assign out_valid   = out_valid_q;
   assign out_duty    = out_duty_q;
   assign busy        = busy_q;
   assign err_timeout = err_timeout_q;
   assign err_range   = err_range_q;

endmodule

// File: doc/duty_meas_ctrl.md
DUTY_MEAS_CTRL -- requirements
Module: duty_meas_ctrl

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2, meaning log2 of samples averaged per result (AVG_N = 2^AVG_LOG2, legal 0..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20_000_000, meaning max clk_10m cycles waiting for one sample (2 s).
REQ-003 SHALL have parameter PERIOD_CYC, default 5_000_000, meaning auto-retrigger interval (0.5 s, used only with the auto feature).
REQ-004 SHALL have parameters DUTY_MIN, default 2000, and DUTY_MAX, default 8000, meaning the accepted sample range in 0.01 % units.
REQ-005 clk_10m  input  1  10 MHz clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin a measurement burst.
REQ-008 meter_valid  input  1  stretched valid from the meter (high about 2 ms per result).
REQ-009 meter_duty  input  16  meter result, stable while meter_valid is high.
REQ-010 meter_rst  output  1  registered reset to the meter, active-high.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_valid  output  1  averaged result available.
REQ-013 out_duty  output  16  averaged duty cycle, 0.01 % units.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_timeout  output  1  one-cycle pulse when a burst is aborted by timeout.
REQ-016 err_range  output  1  one-cycle pulse for each discarded out-of-range sample.

Function
REQ-017 SHALL implement the states IDLE, ARM, WAIT_RES, WAIT_LOW, DONE and ERR.
REQ-018 IDLE: when start=1 (or an auto trigger fires), SHALL clear the accumulator and sample count and go to ARM on the next edge.
REQ-019 ARM: SHALL hold meter_rst=1 for exactly 2 cycles, clear the timeout counter, then enter WAIT_RES.
REQ-020 SHALL register meter_valid once (prev) and define a sample event as meter_valid=1 and prev=0.
REQ-021 WAIT_RES, sample event with DUTY_MIN <= meter_duty <= DUTY_MAX: SHALL add meter_duty to a 20-bit accumulator, increment count, clear the timeout counter and go to WAIT_LOW.
REQ-022 WAIT_RES, sample event out of range: SHALL pulse err_range, leave accumulator and count unchanged, and go to WAIT_LOW without clearing the timeout counter.
REQ-023 WAIT_LOW: SHALL stay until meter_valid=0, so one stretched pulse is counted only once.
REQ-024 WAIT_LOW exit: if count = AVG_N, SHALL load out_duty = accumulator >> AVG_LOG2 (truncating, low 16 bits) and go to DONE; otherwise go to WAIT_RES.
REQ-025 Timeout counter SHALL increment every cycle in WAIT_RES and WAIT_LOW; on reaching TIMEOUT_CYC, SHALL go to ERR.
REQ-026 ERR: SHALL pulse err_timeout for 1 cycle, keep out_valid=0, assert meter_rst for that cycle, and return to IDLE.
REQ-027 DONE: SHALL hold out_valid=1 and out_duty stable until out_ready=1; the transfer completes on the edge where both are 1, clearing out_valid and returning to IDLE.
REQ-028 SHALL ignore start in every state except IDLE, including start coincident with the DONE handshake.
REQ-029 out_duty SHALL keep the last delivered value after the handshake, until the next DONE load.
REQ-030 Latency SHALL be exactly 1 cycle from the WAIT_LOW exit (meter_valid low) to out_valid=1.

Reset
REQ-031 On rst=1, the state SHALL go to IDLE, and the accumulator, count, timeout counter, period counter, prev, out_valid, out_duty, err_timeout and err_range SHALL all be 0.
REQ-032 On rst=1, meter_rst SHALL be 1; it SHALL go to 0 on the first clock edge after rst is released.
REQ-033 A reset mid-burst SHALL discard the partial burst and SHALL NOT produce an out_valid pulse.

Configuration
REQ-034 With DUTY_CTRL_AUTO_EN defined: a period counter SHALL generate an internal trigger every PERIOD_CYC cycles, accepted only in IDLE, OR'd with start; the counter SHALL run freely across all states.
REQ-035 Without DUTY_CTRL_AUTO_EN: there SHALL be no period counter, and bursts SHALL start only from start.

Verification (sim parameters AVG_LOG2=2, TIMEOUT_CYC=1000, PERIOD_CYC=5000)
REQ-036 start; 4 meter pulses with duty 5000, 5002, 5004, 5006 -> out_valid=1, out_duty=5003, busy stays 1 until the handshake.
REQ-037 start; pulses with duty 1500, 9000, then 4 pulses of 3000 -> 2 err_range pulses, out_duty=3000.
REQ-038 start; no meter pulse -> err_timeout pulse 1000 cycles after ARM exits, out_valid never 1, back in IDLE.
REQ-039 DONE with out_ready held 0 for 50 cycles; start pulsed meanwhile -> out_valid and out_duty stable, start ignored, IDLE only after out_ready=1.
REQ-040 rst asserted after 2 accepted samples -> all outputs 0 and meter_rst=1 immediately; a fresh start then needs 4 new samples.
REQ-041 DUTY_CTRL_AUTO_EN defined, no start -> bursts begin at cycles 5000, 10000, ...; undefined -> no burst ever starts.
